// File: rtl/eviction_write_buffer.sv
// rtl/eviction_write_buffer.sv - single-entry victim/write-back buffer between cache and memory
module eviction_write_buffer #(
    parameter int ADDR_W   = 16,
    parameter int LINE_W   = 128,
    parameter int OFFSET_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cache_read,
    input  logic              cache_write,
    input  logic [ADDR_W-1:0] cache_address,
    input  logic [LINE_W-1:0] cache_wdata,
    output logic [LINE_W-1:0] cache_rdata,
    output logic              cache_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    localparam int TAG_W = ADDR_W - OFFSET_W;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_RESP} state_t;

    state_t            r_state;
    logic              r_buf_valid;
    logic [TAG_W-1:0]  r_buf_addr;
    logic [TAG_W-1:0]  r_fill_addr;
    logic [LINE_W-1:0] r_buf_data;
    logic [LINE_W-1:0] r_rdata;
    logic              r_resp;
    logic              r_pmem_read;
    logic              r_pmem_write;

    logic [TAG_W-1:0]  w_line;
    logic              w_hit;
    logic              w_unused_offset;

    assign w_line          = cache_address[ADDR_W-1:OFFSET_W];
    assign w_hit           = r_buf_valid && (w_line == r_buf_addr);
    assign w_unused_offset = ^cache_address[OFFSET_W-1:0];

    // Read wins over write; a write that misses a valid buffer (or no request at all)
    // sends the buffered line to memory first, the write is re-evaluated afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_buf_valid  <= 1'b0;
            r_buf_addr   <= '0;
            r_fill_addr  <= '0;
            r_buf_data   <= '0;
            r_rdata      <= '0;
            r_resp       <= 1'b0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
        end else begin
            r_resp <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cache_read && w_hit) begin
                        r_rdata <= r_buf_data;
                        r_resp  <= 1'b1;
                        r_state <= S_RESP;
                    end else if (cache_read) begin
                        r_fill_addr <= w_line;
                        r_pmem_read <= 1'b1;
                        r_state     <= S_FILL;
                    end else if (cache_write && (!r_buf_valid || w_hit)) begin
                        r_buf_data  <= cache_wdata;
                        r_buf_addr  <= w_line;
                        r_buf_valid <= 1'b1;
                        r_resp      <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_buf_valid) begin
                        r_pmem_write <= 1'b1;
                        r_state      <= S_DRAIN;
                    end
                end
                S_FILL: begin
                    if (pmem_resp) begin
                        r_rdata     <= pmem_rdata;
                        r_pmem_read <= 1'b0;
                        r_resp      <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_DRAIN: begin
                    if (pmem_resp) begin
                        r_pmem_write <= 1'b0;
                        r_buf_valid  <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        pmem_address = '0;
        if (r_state == S_FILL) begin
            pmem_address = {r_fill_addr, {OFFSET_W{1'b0}}};
        end else if (r_state == S_DRAIN) begin
            pmem_address = {r_buf_addr, {OFFSET_W{1'b0}}};
        end
    end

    assign cache_rdata = r_rdata;
    assign cache_resp  = r_resp;
    assign pmem_read   = r_pmem_read;
    assign pmem_write  = r_pmem_write;
    assign pmem_wdata  = r_buf_data;
endmodule

// File: tb/tb_eviction_write_buffer.sv
// tb/tb_eviction_write_buffer.sv - directed and random checks of eviction_write_buffer against a transaction model
module tb_eviction_write_buffer;
    logic         clk = 1'b0;
    logic         rst;
    logic         cache_read, cache_write;
    logic [15:0]  cache_address;
    logic [127:0] cache_wdata, cache_rdata;
    logic         cache_resp;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    int checks = 0;
    int failures = 0;

    eviction_write_buffer dut (
        .clk(clk), .rst(rst),
        .cache_read(cache_read), .cache_write(cache_write),
        .cache_address(cache_address), .cache_wdata(cache_wdata),
        .cache_rdata(cache_rdata), .cache_resp(cache_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] data;
    } op_t;

    // Transaction-level model: one buffered line plus a line-addressed memory image.
    logic         m_bv;
    logic [11:0]  m_bl;
    logic [127:0] m_bd;
    logic [127:0] m_mem [logic [11:0]];
    op_t          expq [$];

    // Physical memory and responder seen by the DUT.
    logic [127:0] pm [logic [11:0]];
    op_t          oplog [$];
    logic         outst = 1'b0;
    logic         resp_en = 1'b1;
    int           cd = 0;
    int           force_lat = -1;
    int           cyc = 0;
    int           last_presp_cyc = -10;
    logic         prev_resp = 1'b0;

    function automatic logic [127:0] init_val(logic [11:0] ln);
        return {8{ln, 4'h5}};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [11:0] ln;
        @(negedge clk);
        cyc++;
        chk("pmem_rd_wr_exclusive", 128'(pmem_read & pmem_write), 128'(0));
        chk("cache_resp_one_cycle", 128'(prev_resp & cache_resp), 128'(0));
        prev_resp = cache_resp;
        pmem_resp = 1'b0;
        if (!outst && (pmem_read || pmem_write) && !rst) begin
            oplog.push_back('{pmem_write, pmem_address, pmem_write ? pmem_wdata : 128'(0)});
            outst = 1'b1;
            cd = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
        end
        if (outst && resp_en) begin
            if (cd == 0) begin
                pmem_resp = 1'b1;
                ln = pmem_address[15:4];
                if (pmem_write) pm[ln] = pmem_wdata;
                else pmem_rdata = pm.exists(ln) ? pm[ln] : init_val(ln);
                outst = 1'b0;
                last_presp_cyc = cyc;
            end else begin
                cd--;
            end
        end
    endtask

    task automatic check_ops();
        op_t o, e;
        chk("pmem_op_count", 128'(oplog.size()), 128'(expq.size()));
        while (oplog.size() > 0 && expq.size() > 0) begin
            o = oplog.pop_front();
            e = expq.pop_front();
            chk("pmem_op_kind", 128'(o.wr), 128'(e.wr));
            chk("pmem_op_addr", 128'(o.addr), 128'(e.addr));
            chk("pmem_op_wdata", o.data, e.data);
        end
        oplog.delete();
        expq.delete();
    endtask

    task automatic req(logic wr, logic [15:0] a, logic [127:0] d);
        logic [11:0]  ln;
        logic         hit, nopmem, b2b, got;
        logic [127:0] exp_rd;
        int           n;
        ln     = a[15:4];
        hit    = m_bv && (m_bl == ln);
        nopmem = 1'b0;
        exp_rd = '0;
        b2b    = prev_resp;
        if (!wr) begin
            if (hit) begin
                exp_rd = m_bd;
                nopmem = 1'b1;
            end else begin
                expq.push_back('{1'b0, {ln, 4'h0}, 128'(0)});
                exp_rd = m_mem.exists(ln) ? m_mem[ln] : init_val(ln);
            end
        end else begin
            if (m_bv && !hit) begin
                expq.push_back('{1'b1, {m_bl, 4'h0}, m_bd});
                m_mem[m_bl] = m_bd;
            end else begin
                nopmem = 1'b1;
            end
            m_bv = 1'b1;
            m_bl = ln;
            m_bd = d;
        end
        cache_read    = !wr;
        cache_write   = wr;
        cache_address = a;
        cache_wdata   = d;
        got = 1'b0;
        for (n = 1; n <= 200; n++) begin
            cycle();
            if (cache_resp) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("cache_resp_timeout", 128'(0), 128'(1));
        else if (nopmem) chk("local_latency", 128'(n), b2b ? 128'(2) : 128'(1));
        else if (!wr) chk("miss_latency", 128'(cyc - last_presp_cyc), 128'(1));
        if (got && !wr) chk("cache_rdata", cache_rdata, exp_rd);
        cache_read  = 1'b0;
        cache_write = 1'b0;
        check_ops();
    endtask

    task automatic idle();
        if (m_bv) begin
            expq.push_back('{1'b1, {m_bl, 4'h0}, m_bd});
            m_mem[m_bl] = m_bd;
            m_bv = 1'b0;
        end
        for (int n = 0; n < 100; n++) begin
            cycle();
            if (oplog.size() >= expq.size() && !outst) break;
        end
        for (int n = 0; n < 3; n++) cycle();
        check_ops();
    endtask

    initial begin
        logic [127:0] d1, d2, d3;
        logic [11:0]  pool [4];
        logic [15:0]  a;
        int           r;
        logic         got;
        rst = 1'b1;
        cache_read = 1'b0; cache_write = 1'b0;
        cache_address = '0; cache_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        m_bv = 1'b0; m_bl = '0; m_bd = '0;
        d1 = rnd128(); d2 = rnd128(); d3 = rnd128();
        pool[0] = 12'h123; pool[1] = 12'h456; pool[2] = 12'h777; pool[3] = 12'h9ab;

        cycle(); cycle();
        chk("reset_cache_resp", 128'(cache_resp), 128'(0));
        chk("reset_pmem_read", 128'(pmem_read), 128'(0));
        chk("reset_pmem_write", 128'(pmem_write), 128'(0));
        chk("reset_cache_rdata", cache_rdata, 128'(0));
        rst = 1'b0;
        cycle();

        // write capture then idle drain
        req(1'b1, 16'h1230, d1);
        idle();
        // buffer hit on a different offset of the same line
        req(1'b1, 16'h1230, d1);
        req(1'b0, 16'h1238, 128'(0));
        // miss goes to memory before the buffered line drains
        force_lat = 5;
        req(1'b0, 16'h4560, 128'(0));
        force_lat = -1;
        idle();
        // write to another line evicts the buffered one first
        req(1'b1, 16'h1230, d1);
        req(1'b1, 16'h7770, d2);
        idle();
        // same-line writes coalesce into one drain
        req(1'b1, 16'h1230, d1);
        req(1'b1, 16'h1234, d3);
        idle();

        // reset two cycles into a drain discards the line
        req(1'b1, 16'h1230, d2);
        resp_en = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 50; n++) begin
            cycle();
            if (pmem_write) begin
                got = 1'b1;
                break;
            end
        end
        chk("drain_started", 128'(got), 128'(1));
        cycle(); cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_pmem_write", 128'(pmem_write), 128'(0));
        chk("rst_pmem_read", 128'(pmem_read), 128'(0));
        chk("rst_cache_resp", 128'(cache_resp), 128'(0));
        chk("rst_cache_rdata", cache_rdata, 128'(0));
        resp_en = 1'b1;
        expq.push_back('{1'b1, 16'h1230, d2});
        m_bv = 1'b0;
        for (int n = 0; n < 8; n++) cycle();
        check_ops();
        req(1'b0, 16'h1230, 128'(0));
        idle();

        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            a = {pool[$urandom_range(0, 3)], 4'($urandom_range(0, 15))};
            if (r < 4) req(1'b0, a, 128'(0));
            else if (r < 8) req(1'b1, a, rnd128());
            else idle();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
